// File: rtl/composite_timing.sv
// Composite video raster timing: prescaler, line/field counters, sync/blank/active-index decode.
// Latency: all outputs registered; they present the new hc/vc on the same edge that raises pix_ce.
// Backpressure: none; en=0 freezes prescaler, counters and outputs. Option macro: COMPOSITE_TIMING_BROAD_EN.
module composite_timing #(
    parameter int CLK_DIV  = 4,
    parameter int H_TOTAL  = 384,
    parameter int H_SYNC   = 28,
    parameter int H_BACK   = 34,
    parameter int H_ACTIVE = 312,
    parameter int V_TOTAL  = 312,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 19,
    parameter int V_ACTIVE = 288
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       pix_ce,
    output logic       sync_n,
    output logic       blank,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       frame_start
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [PW-1:0] P_MAX   = PW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_MAX   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_MAX   = VW'(V_TOTAL - 1);
    // One extra bit so window ends equal to TOTAL still compare correctly.
    localparam logic [HW:0]   H_START = (HW+1)'(H_SYNC + H_BACK);
    localparam logic [HW:0]   H_END   = (HW+1)'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [HW:0]   H_SYNCL = (HW+1)'(H_SYNC);
    localparam logic [VW:0]   V_START = (VW+1)'(V_SYNC + V_BACK);
    localparam logic [VW:0]   V_END   = (VW+1)'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [VW:0]   V_SYNCL = (VW+1)'(V_SYNC);
`ifdef COMPOSITE_TIMING_BROAD_EN
    localparam logic [HW:0]   H_BROAD = (HW+1)'(H_TOTAL - H_SYNC);
`endif

    logic [PW-1:0] presc;
    logic [HW-1:0] hc, hc_nxt, xd;
    logic [VW-1:0] vc, vc_nxt, yd;
    logic          wrap, h_wrap, act, sync_nxt;

    // Next-sample position and the output decode of that position.
    always_comb begin
        wrap     = (presc == P_MAX);
        h_wrap   = (hc == H_MAX);
        hc_nxt   = h_wrap ? '0 : hc + 1'b1;
        vc_nxt   = vc;
        if (h_wrap) begin
            vc_nxt = (vc == V_MAX) ? '0 : vc + 1'b1;
        end
        act      = ({1'b0, hc_nxt} >= H_START) && ({1'b0, hc_nxt} < H_END) &&
                   ({1'b0, vc_nxt} >= V_START) && ({1'b0, vc_nxt} < V_END);
        xd       = hc_nxt - H_START[HW-1:0];
        yd       = vc_nxt - V_START[VW-1:0];
        sync_nxt = 1'b0;
        if ({1'b0, vc_nxt} < V_SYNCL) begin
`ifdef COMPOSITE_TIMING_BROAD_EN
            // Broad pulses: low for most of the line, high for the last H_SYNC samples.
            sync_nxt = ({1'b0, hc_nxt} >= H_BROAD);
`else
            // Plain field sync: whole line at sync level.
            sync_nxt = 1'b0;
`endif
        end else begin
            sync_nxt = ({1'b0, hc_nxt} >= H_SYNCL);
        end
    end

    // Prescaler, counters and registered outputs; updates only on the sample tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            hc          <= '0;
            vc          <= '0;
            pix_ce      <= 1'b0;
            sync_n      <= 1'b0;
            blank       <= 1'b1;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else if (en) begin
            pix_ce <= wrap;
            presc  <= wrap ? '0 : presc + 1'b1;
            if (wrap) begin
                hc          <= hc_nxt;
                vc          <= vc_nxt;
                sync_n      <= sync_nxt;
                blank       <= !act;
                x           <= act ? 10'(xd) : 10'd0;
                y           <= act ? 9'(yd) : 9'd0;
                frame_start <= (hc_nxt == '0) && (vc_nxt == '0);
            end
        end else begin
            pix_ce <= 1'b0;
        end
    end

endmodule

// File: tb/tb_composite_timing.sv
// Bench for composite_timing: instance A uses default timing, instance B a tiny raster with CLK_DIV=1
// so that field wrap and frame_start can be reached quickly. A sample-count model predicts every output.
module tb_composite_timing;

`ifdef COMPOSITE_TIMING_BROAD_EN
    localparam bit BROAD = 1'b1;
`else
    localparam bit BROAD = 1'b0;
`endif
    localparam int DIV_A = 4;
    localparam int DIV_B = 1;

    typedef struct packed {
        logic       pix;
        logic       sync;
        logic       blank;
        logic [9:0] x;
        logic [8:0] y;
        logic       fs;
    } outs_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0, en_a = 1'b1, rst_b = 1'b0, en_b = 1'b1;
    logic pix_a, sync_a, blank_a, fs_a, pix_b, sync_b, blank_b, fs_b;
    logic [9:0] x_a, x_b;
    logic [8:0] y_a, y_b;

    int  total = 0;
    int  bad = 0;
    bit  run = 1'b1;
    int  ecnt_a = 0, ecnt_b = 0, n_a, n_b;
    bit  tick_a = 1'b0, tick_b = 1'b0;
    int  low_a [0:7] = '{default: 0};

    always #5 clk = ~clk;

    composite_timing u_a (
        .clk(clk), .rst_n(rst_a), .en(en_a), .pix_ce(pix_a), .sync_n(sync_a),
        .blank(blank_a), .x(x_a), .y(y_a), .frame_start(fs_a)
    );

    composite_timing #(
        .CLK_DIV(DIV_B), .H_TOTAL(16), .H_SYNC(2), .H_BACK(3), .H_ACTIVE(10),
        .V_TOTAL(10), .V_SYNC(2), .V_BACK(2), .V_ACTIVE(5)
    ) u_b (
        .clk(clk), .rst_n(rst_b), .en(en_b), .pix_ce(pix_b), .sync_n(sync_b),
        .blank(blank_b), .x(x_b), .y(y_b), .frame_start(fs_b)
    );

    // Model: count enabled clocks since reset; a sample tick is every DIV-th of them.
    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            ecnt_a <= 0; tick_a <= 1'b0;
        end else if (en_a) begin
            ecnt_a <= ecnt_a + 1; tick_a <= ((ecnt_a + 1) % DIV_A == 0);
        end else begin
            tick_a <= 1'b0;
        end
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ecnt_b <= 0; tick_b <= 1'b0;
        end else if (en_b) begin
            ecnt_b <= ecnt_b + 1; tick_b <= ((ecnt_b + 1) % DIV_B == 0);
        end else begin
            tick_b <= 1'b0;
        end
    end

    always_comb n_a = ecnt_a / DIV_A;
    always_comb n_b = ecnt_b / DIV_B;

    // Outputs as a function of the number of samples elapsed since reset.
    function automatic outs_t model(input int n, input bit tk, input int ht, input int hs, input int hb,
                                    input int ha, input int vt, input int vs, input int vb, input int va);
        int hc, vc;
        bit act;
        outs_t o;
        hc  = n % ht;
        vc  = (n / ht) % vt;
        act = (hc >= hs + hb) && (hc < hs + hb + ha) && (vc >= vs + vb) && (vc < vs + vb + va);
        o.pix   = tk;
        o.blank = !act;
        o.x     = act ? 10'(hc - hs - hb) : 10'd0;
        o.y     = act ? 9'(vc - vs - vb) : 9'd0;
        if (vc < vs) o.sync = BROAD ? (hc >= ht - hs) : 1'b0;
        else         o.sync = (hc >= hs);
        o.fs    = (n > 0) && (hc == 0) && (vc == 0);
        return o;
    endfunction

    task automatic cmp(input string nm, input outs_t got, input outs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got pix=%0b sync=%0b blank=%0b x=%0d y=%0d fs=%0b required pix=%0b sync=%0b blank=%0b x=%0d y=%0d fs=%0b",
                     nm, $time, got.pix, got.sync, got.blank, got.x, got.y, got.fs,
                     exp.pix, exp.sync, exp.blank, exp.x, exp.y, exp.fs);
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s t=%0t got %0d required %0d", nm, $time, got, exp);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (run) begin
            cmp("model_a", {pix_a, sync_a, blank_a, x_a, y_a, fs_a},
                model(n_a, tick_a, 384, 28, 34, 312, 312, 3, 19, 288));
            cmp("model_b", {pix_b, sync_b, blank_b, x_b, y_b, fs_b},
                model(n_b, tick_b, 16, 2, 3, 10, 10, 2, 2, 5));
            if (pix_a && (n_a / 384) < 8 && !sync_a) low_a[n_a / 384]++;
        end
    end

    task automatic wait_tick(input bit b, input int target, input int limit);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            if (b ? (pix_b && n_b == target) : (pix_a && n_a == target)) hit = 1'b1;
        end
        if (!hit) begin
            total++; bad++;
            $display("FAIL wait_tick inst=%0d got n=%0d required n=%0d", b, b ? n_b : n_a, target);
        end
    endtask

    task automatic clks_to_tick(input string nm, input int exp);
        int cnt;
        bit hit;
        cnt = 0; hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (pix_a) hit = 1'b1;
        end
        chk(nm, cnt, exp);
    endtask

    task automatic reset_vals_a(input string nm);
        chk({nm, "_pix"}, int'(pix_a), 0);
        chk({nm, "_sync"}, int'(sync_a), 0);
        chk({nm, "_blank"}, int'(blank_a), 1);
        chk({nm, "_x"}, int'(x_a), 0);
        chk({nm, "_y"}, int'(y_a), 0);
        chk({nm, "_fs"}, int'(fs_a), 0);
    endtask

    task automatic stim_a;
        repeat (3) @(negedge clk);
        reset_vals_a("a_in_reset");
        @(posedge clk); #2 rst_a = 1'b1;
        clks_to_tick("a_first_tick_clks", 4);
        clks_to_tick("a_tick_period", 4);
        wait_tick(1'b0, 3 * 384 - 1, 6000);
        chk("a_vc2_hc383_sync", int'(sync_a), BROAD ? 1 : 0);
        wait_tick(1'b0, 3 * 384, 10);
        chk("a_vc3_hc0_sync", int'(sync_a), 0);
        wait_tick(1'b0, 3 * 384 + 28, 200);
        chk("a_vc3_hc28_sync", int'(sync_a), 1);
        wait_tick(1'b0, 5 * 384, 4000);
        chk("a_line1_low", low_a[1], BROAD ? 356 : 384);
        chk("a_line4_low", low_a[4], 28);
        wait_tick(1'b0, 22 * 384 + 61, 30000);
        chk("a_hc61_blank", int'(blank_a), 1);
        wait_tick(1'b0, 22 * 384 + 62, 10);
        chk("a_hc62_blank", int'(blank_a), 0);
        chk("a_hc62_x", int'(x_a), 0);
        chk("a_hc62_y", int'(y_a), 0);
        wait_tick(1'b0, 22 * 384 + 100, 200);
        chk("a_hc100_x", int'(x_a), 38);
        #1 en_a = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("a_frozen_pix", int'(pix_a), 0);
            chk("a_frozen_x", int'(x_a), 38);
        end
        #1 en_a = 1'b1;
        wait_tick(1'b0, 22 * 384 + 101, 8);
        chk("a_resume_x", int'(x_a), 39);
        wait_tick(1'b0, 22 * 384 + 373, 1200);
        chk("a_hc373_x", int'(x_a), 311);
        chk("a_hc373_blank", int'(blank_a), 0);
        wait_tick(1'b0, 22 * 384 + 374, 10);
        chk("a_hc374_blank", int'(blank_a), 1);
        chk("a_hc374_x", int'(x_a), 0);
        wait_tick(1'b0, 23 * 384 + 200, 1200);
        chk("a_vc23_y", int'(y_a), 1);
        chk("a_vc23_x", int'(x_a), 138);
        @(posedge clk); #2 rst_a = 1'b0;
        #1 reset_vals_a("a_async_reset");
        repeat (3) @(posedge clk);
        #2 rst_a = 1'b1;
        clks_to_tick("a_rerelease_tick_clks", 4);
        chk("a_after_reset_sync", int'(sync_a), 0);
        chk("a_after_reset_blank", int'(blank_a), 1);
        chk("a_after_reset_fs", int'(fs_a), 0);
    endtask

    task automatic stim_b;
        repeat (3) @(negedge clk);
        chk("b_in_reset_blank", int'(blank_b), 1);
        @(posedge clk); #2 rst_b = 1'b1;
        @(posedge clk); #1;
        chk("b_first_tick", int'(pix_b), 1);
        wait_tick(1'b1, 30, 100);
        chk("b_vc1_hc14_sync", int'(sync_b), BROAD ? 1 : 0);
        wait_tick(1'b1, 69, 100);
        chk("b_first_active_blank", int'(blank_b), 0);
        chk("b_first_active_x", int'(x_b), 0);
        wait_tick(1'b1, 142, 100);
        chk("b_last_active_x", int'(x_b), 9);
        chk("b_last_active_y", int'(y_b), 4);
        wait_tick(1'b1, 149, 20);
        chk("b_vc9_blank", int'(blank_b), 1);
        wait_tick(1'b1, 159, 20);
        chk("b_field_end_fs", int'(fs_b), 0);
        chk("b_field_end_sync", int'(sync_b), 1);
        wait_tick(1'b1, 160, 5);
        chk("b_wrap_fs", int'(fs_b), 1);
        chk("b_wrap_sync", int'(sync_b), 0);
        wait_tick(1'b1, 161, 5);
        chk("b_after_wrap_fs", int'(fs_b), 0);
        wait_tick(1'b1, 247, 100);
        chk("b_midfield_x", int'(x_b), 2);
        chk("b_midfield_y", int'(y_b), 1);
        @(posedge clk); #2 rst_b = 1'b0;
        #1;
        chk("b_async_reset_pix", int'(pix_b), 0);
        chk("b_async_reset_blank", int'(blank_b), 1);
        chk("b_async_reset_x", int'(x_b), 0);
        repeat (2) @(posedge clk);
        #2 rst_b = 1'b1;
        @(posedge clk); #1;
        chk("b_rerelease_tick", int'(pix_b), 1);
        wait_tick(1'b1, 159, 200);
        chk("b_refield_end_fs", int'(fs_b), 0);
        wait_tick(1'b1, 160, 5);
        chk("b_refield_wrap_fs", int'(fs_b), 1);
    endtask

    initial begin
        fork
            stim_a;
            stim_b;
        join
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got no completion required completion", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/composite_timing.md
COMPOSITE_TIMING -- requirements
Module: composite_timing

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 4, meaning clk cycles per sample tick (minimum 1).
REQ-002 The module SHALL have parameter H_TOTAL, default 384, meaning samples per line (64 us at 6 MHz).
REQ-003 The module SHALL have parameters H_SYNC=28, H_BACK=34 and H_ACTIVE=312, meaning sync, back-porch and active samples per line.
REQ-004 The module SHALL have parameter V_TOTAL, default 312, meaning lines per field.
REQ-005 The module SHALL have parameters V_SYNC=3, V_BACK=19 and V_ACTIVE=288, meaning sync, back-porch and active lines per field.
REQ-006 Port clk  input  1  system clock (24 MHz oscillator).
REQ-007 Port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-008 Port en  input  1  count enable; low freezes all counters and outputs.
REQ-009 Port pix_ce  output  1  one-clk sample strobe for the downstream composite encoder.
REQ-010 Port sync_n  output  1  composite sync; low means sync level.
REQ-011 Port blank  output  1  high outside the active window.
REQ-012 Port x  output  10  active-sample index; 0 when blank.
REQ-013 Port y  output  9  active-line index; 0 when blank.
REQ-014 Port frame_start  output  1  one-pix_ce pulse at sample 0 of line 0.

Function
REQ-015 The prescaler SHALL count 0..CLK_DIV-1 while en=1 and assert pix_ce for exactly one clk when it wraps to 0; for CLK_DIV=1, pix_ce SHALL be held high while en=1.
REQ-016 Horizontal counter hc SHALL advance by 1 on each pix_ce and wrap from H_TOTAL-1 to 0.
REQ-017 Vertical counter vc SHALL advance by 1 only on the pix_ce that wraps hc, and SHALL wrap from V_TOTAL-1 to 0.
REQ-018 All outputs SHALL be registered and, on the edge where pix_ce is high, SHALL reflect the new hc/vc values.
REQ-019 Active SHALL be defined as hc in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) and vc in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE).
REQ-020 When active, x SHALL equal hc-(H_SYNC+H_BACK), y SHALL equal vc-(V_SYNC+V_BACK) and blank SHALL be 0; otherwise x=0, y=0 and blank=1.
REQ-021 On lines vc>=V_SYNC, sync_n SHALL be 0 for hc<H_SYNC and 1 otherwise.
REQ-022 On lines vc<V_SYNC, sync_n SHALL follow REQ-034/REQ-035.
REQ-023 frame_start SHALL be 1 exactly when hc=0 and vc=0, and SHALL be 0 otherwise.
REQ-024 While en=0: the prescaler, hc and vc SHALL hold, pix_ce SHALL be 0, and all other outputs SHALL hold.
REQ-025 When en rises, counting SHALL resume from the held state with no skipped or repeated sample.
REQ-026 Counter widths SHALL be the minimum that holds the parameter range, and no counter SHALL exceed its TOTAL-1.

Reset
REQ-027 The rst_n assert SHALL be asynchronous and its deassert SHALL take effect synchronously to clk.
REQ-028 On reset, the prescaler, hc and vc SHALL be 0.
REQ-029 Reset values SHALL be: pix_ce=0, sync_n=0, blank=1, x=0, y=0, frame_start=0.
REQ-030 After deassert, the first pix_ce SHALL occur CLK_DIV clks later with hc=1, vc=0.
REQ-031 Reset asserted mid-line or mid-field SHALL abandon the current line and field immediately, with no completion.
REQ-032 The first frame_start SHALL occur after one full field following reset.

Configuration
REQ-033 Macro COMPOSITE_TIMING_BROAD_EN SHALL select the field-sync style.
REQ-034 With COMPOSITE_TIMING_BROAD_EN defined, lines vc<V_SYNC SHALL carry broad pulses: sync_n=0 for hc<H_TOTAL-H_SYNC and 1 for the final H_SYNC samples.
REQ-035 With COMPOSITE_TIMING_BROAD_EN undefined, lines vc<V_SYNC SHALL hold sync_n=0 for the entire line.

Verification
REQ-036 Defaults, en=1, 2 lines: pix_ce period is 4 clk; sync_n low for 28 samples per line; hc wraps 383->0 and vc increments 3->4.
REQ-037 Active window: at line vc=22, hc=62 -> blank=0, x=0, y=0; at hc=373 -> x=311; at hc=374 -> blank=1, x=0.
REQ-038 Field wrap: at vc=311, hc=383 -> next pix_ce gives vc=0, frame_start=1 for one tick only; frame_start is 0 on the following tick.
REQ-039 Broad sync: line 1 with macro defined -> sync_n low for 356 samples, then high for 28; without macro -> sync_n low all 384 samples.
REQ-040 en=0 held for 10 clks mid-line at hc=100 -> no pix_ce and outputs frozen; after en=1 the next tick gives hc=101.
REQ-041 rst_n pulled low at vc=150, hc=200 -> outputs take reset values immediately (no clk edge); after release, the first tick has hc=1, vc=0.
